// File: rtl/uart_hex_pkg.sv
// Shared types, constants and helpers for the UART hex transmitter.
// UART_HEX_CRLF_EN appends CR LF after the two hex characters.
package uart_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UART_HEX_CRLF_EN
  localparam int NUM_CHARS = 4;
`else
  localparam int NUM_CHARS = 2;
`endif

  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  // Upper-case hex digit: '0'..'9' then 'A'..'F' (0x37 + n for n >= 10).
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10) nibble_to_ascii = 8'h30 + n8;
    else nibble_to_ascii = 8'h37 + n8;
  endfunction

endpackage

// File: rtl/uart_byte_serializer.sv
// 8N1 frame serializer: owns baud counter, bit counter and frame FSM.
// Accepts a new character in the last stop-bit cycle so frames run back-to-back.
module uart_byte_serializer
  import uart_hex_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_i,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       frame_done,
  output logic       txd,
  output state_t     state_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              baud_last;

  assign baud_last  = (baud_q == BAUD_LAST);
  assign char_ready = (state_q == IDLE) || ((state_q == STOP) && baud_last);
  assign frame_done = (state_q == STOP) && baud_last;
  assign txd        = txd_q;
  assign state_o    = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    if (state_q == IDLE || baud_last) baud_d = '0;
    else baud_d = baud_q + 1'b1;

    // txd_d is the level the line takes on the cycle after a bit boundary.
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (char_valid) begin
          state_d = START;
          shreg_d = char_i;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = 3'd0;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (char_valid) begin
            state_d = START;
            shreg_d = char_i;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Sends one handshaken byte as two ASCII hex characters over UART 8N1.
// With UART_HEX_CRLF_EN defined, CR LF follows the hex pair.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready is high only when idle and out of reset, and in_valid is ignored otherwise.
module uart_hex_tx
  import uart_hex_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       uart_txd
);

  logic             active_q, active_d;
  logic [7:0]       byte_q, byte_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hs;
  logic [7:0]       ser_char;
  logic             ser_valid, ser_ready, ser_done;
  state_t           ser_state;

  function automatic logic [7:0] char_at(input logic [7:0] b, input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    char_at = nibble_to_ascii(b[7:4]);
      2'd1:    char_at = nibble_to_ascii(b[3:0]);
      2'd2:    char_at = ASCII_CR;
      default: char_at = ASCII_LF;
    endcase
  endfunction

  assign in_ready = rst_n && !active_q && (ser_state == IDLE);
  assign hs       = in_valid && in_ready;
  assign busy     = active_q;

  // First character goes straight from the input so its start bit appears next cycle.
  assign ser_valid = hs || (active_q && (idx_q != LAST_IDX));
  assign ser_char  = hs ? nibble_to_ascii(in_data[7:4]) : char_at(byte_q, idx_q + 2'd1);

  uart_byte_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_i    (ser_char),
    .char_valid(ser_valid),
    .char_ready(ser_ready),
    .frame_done(ser_done),
    .txd       (uart_txd),
    .state_o   (ser_state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      byte_q   <= '0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    active_d = active_q;
    byte_d   = byte_q;
    idx_d    = idx_q;
    if (hs) begin
      active_d = 1'b1;
      byte_d   = in_data;
      idx_d    = '0;
    end else if (active_q) begin
      if (ser_valid && ser_ready) idx_d = idx_q + 2'd1;
      else if (ser_done && (idx_q == LAST_IDX)) active_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx: a fast instance (4 clocks/bit) and a 217 clocks/bit instance.
module tb_uart_hex_tx;

`ifdef UART_HEX_CRLF_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel;
  logic       in_valid_f, in_ready_f, busy_f, txd_f;
  logic       in_valid_s, in_ready_s, busy_s, txd_s;
  logic       in_ready, busy, txd;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign in_valid_f = sel ? 1'b0 : in_valid;
  assign in_valid_s = sel ? in_valid : 1'b0;
  assign in_ready   = sel ? in_ready_s : in_ready_f;
  assign busy       = sel ? busy_s : busy_f;
  assign txd        = sel ? txd_s : txd_f;

  uart_hex_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_data(in_data),
    .in_ready(in_ready_f), .busy(busy_f), .uart_txd(txd_f)
  );

  uart_hex_tx #(.CLKS_PER_BIT(217)) dut_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_data(in_data),
    .in_ready(in_ready_s), .busy(busy_s), .uart_txd(txd_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [7:0] b, input int k);
    int n;
    if (k >= 2) return (k == 2) ? 8'h0D : 8'h0A;
    n = (k == 0) ? int'(b[7:4]) : int'(b[3:0]);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  // Presents a byte at a falling edge; returns at the falling edge after the handshake edge.
  task automatic start_msg(input logic [7:0] b, input bit hold, input logic [7:0] nxt);
    in_valid = 1'b1;
    in_data  = b;
    check("ready_before_hs", in_ready, 1);
    @(negedge clk);
    in_valid = hold;
    in_data  = nxt;
  endtask

  // Walks every cycle of the message checking exact bit levels and decoding each character.
  task automatic check_msg(input logic [7:0] b, input int cpb, input bit intrude);
    int         busy_cnt;
    logic [7:0] got;
    logic [7:0] ec;
    logic       eb;
    bit         stable;
    busy_cnt = 0;
    for (int k = 0; k < N; k++) begin
      ec     = exp_char(b, k);
      got    = 8'h00;
      stable = 1'b1;
      for (int j = 0; j < 10; j++) begin
        for (int s = 0; s < cpb; s++) begin
          eb = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : ec[j-1];
          if (txd !== eb) stable = 1'b0;
          if (s == cpb / 2 && j >= 1 && j <= 8) got[j-1] = txd;
          if (busy === 1'b1) busy_cnt++;
          if (intrude && k == 1 && j == 2 && s == 0) begin
            in_valid = 1'b1;
            in_data  = 8'hAB;
          end else if (intrude && k == 1 && j == 2 && s == 1) begin
            in_valid = 1'b0;
          end
          @(negedge clk);
        end
      end
      check($sformatf("char%0d_of_%02h", k, b), got, ec);
      check($sformatf("frame%0d_timing_of_%02h", k, b), stable, 1);
    end
    check("busy_cycles", busy_cnt, N * 10 * cpb);
    check("busy_after_msg", busy, 0);
    check("ready_after_msg", in_ready, 1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check(tag, bad, 0);
  endtask

  initial begin
    sel      = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", in_ready, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    idle_check("idle_after_reset", 5);

    // 0x3A: txd low on the first cycle after the handshake edge.
    start_msg(8'h3A, 1'b0, 8'h00);
    check("start_bit_latency", txd, 0);
    check("busy_at_start", busy, 1);
    check("ready_at_start", in_ready, 0);
    check_msg(8'h3A, 4, 1'b0);
    idle_check("idle_after_3a", 4);

    // Back-to-back with in_valid held high.
    start_msg(8'h00, 1'b1, 8'hFF);
    check_msg(8'h00, 4, 1'b0);
    start_msg(8'hFF, 1'b0, 8'h00);
    check_msg(8'hFF, 4, 1'b0);

    // in_valid pulsed while busy must be dropped.
    start_msg(8'h12, 1'b0, 8'h00);
    check_msg(8'h12, 4, 1'b1);
    idle_check("intruder_never_sent", 20);

    // Reset during the second character's data bits.
    start_msg(8'h5E, 1'b0, 8'h00);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_txd", txd, 1);
    check("abort_busy", busy, 0);
    check("abort_ready_in_reset", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", in_ready, 1);
    idle_check("abort_line_quiet", 60);

    // Slow instance: each bit held for exactly 217 cycles, no gaps.
    sel = 1'b1;
    @(negedge clk);
    start_msg(8'hC5, 1'b0, 8'h00);
    check("slow_start_bit", txd, 0);
    check_msg(8'hC5, 217, 1'b0);
    idle_check("slow_idle_after", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_hex_tx.md
Name: uart_hex_tx

Overview:
- Transmit-side counterpart to the receive/display path.
- Accepts one byte over a valid/ready handshake and sends it over UART 8N1 as printable ASCII hex: high nibble, then low nibble, optionally followed by CR LF.
- Lets a host terminal read the byte directly.
- Sits between board logic (switches, counters, received data) and the TX pin. Pin polarity inversion stays in the top level.

Parameters:
- CLKS_PER_BIT, 217: clock cycles per UART bit (25 MHz / 115200). Minimum legal value 2.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_data is presented for transfer.
- in_data  input  8  byte to be sent as hex.
- in_ready  output  1  block can accept a byte this cycle.
- busy  output  1  a message is in progress.
- uart_txd  output  1  serial line; idle/mark = 1.

Behaviour:
- Interface decision: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset values, held while rst_n = 0: uart_txd = 1, busy = 0, in_ready = 0, state = IDLE, all counters = 0.
- in_ready = 1 only in IDLE with rst_n = 1. Combinational from state.
- Handshake:
  - A transfer occurs on a cycle with in_valid & in_ready. in_data is latched on that edge.
  - The next cycle shows state = START, busy = 1, in_ready = 0 and uart_txd = 0 (start bit).
  - in_valid is ignored while busy; no queueing.
- Character sequence, index 0..N-1 (N = 4 with UART_HEX_CRLF_EN, else 2):
  - hex(in_data[7:4]), hex(in_data[3:0]), 0x0D, 0x0A.
  - hex(n) = 0x30+n for n = 0..9; 0x41+(n-10) for n = 10..15 (upper case).
- Frame per character: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Characters are back-to-back. The next character's start bit begins the cycle after the previous stop bit's last clock, with no idle gap.
- FSM states:
  - IDLE -> START on handshake.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if char index < N-1 (index increments).
  - STOP -> IDLE if char index = N-1.
- Message length: exactly N*10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- After the final stop bit: IDLE, busy = 0, in_ready = 1 on the next cycle.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Bit counter 0..7; char index 0..N-1.
- Reset mid-message: the frame aborts on that edge. uart_txd = 1 from the next cycle, and nothing resumes after reset releases.
- Handshake and reset asserted on the same edge: reset wins and the byte is dropped.
- uart_txd is registered, so no glitches.

Optional Feature:
- Macro UART_HEX_CRLF_EN.
- Defined: N = 4; each byte is sent as "HL\r\n".
- Undefined: N = 2; only the two hex characters are sent. Message length halves and in_ready returns after 20*CLKS_PER_BIT cycles.

Decomposition:
- Package uart_hex_pkg holds:
  - state enum {IDLE, START, DATA, STOP}
  - ASCII_CR = 8'h0D, ASCII_LF = 8'h0A
  - function nibble_to_ascii(4-bit) -> 8-bit
  - localparam NUM_CHARS, derived from the macro
- One natural sub-module: uart_byte_serializer.
  - Owns the baud counter, bit counter and frame FSM.
  - Interface: char in, char_valid/char_ready, txd out.
- The top of the block sequences characters into the serializer.

Test Plan:
- CLKS_PER_BIT = 4, macro on, send 0x3A: line decodes 0x33, 0x41, 0x0D, 0x0A. uart_txd goes low 1 cycle after handshake. busy is high for exactly 160 cycles; in_ready returns on cycle 161.
- Send 0x00, then 0xFF back-to-back, with in_valid held high: chars 0x30 0x30 0D 0A, then 0x46 0x46 0D 0A. The second handshake occurs on the first cycle in_ready returns.
- While busy sending 0x12, pulse in_valid with 0xAB: output remains 0x31 0x32 0D 0A and 0xAB is never sent.
- Assert rst_n = 0 for 1 cycle during the 2nd character's data bits: uart_txd = 1 the next cycle, busy = 0, in_ready = 1 after release. No further edges on the line.
- Macro off, CLKS_PER_BIT = 4, send 0xC5: only 0x43, 0x35 are sent; busy lasts 80 cycles.
- Bit timing check with CLKS_PER_BIT = 217: each bit is stable for exactly 217 cycles, with no idle cycle between characters.
